// File: rtl/mem_dump_monitor.sv
// mem_dump_monitor
// End-of-run monitor for the pipelined MIPS core. It watches the data-memory
// write port for a sentinel store and also runs a cycle watchdog. When either
// one fires, it streams a fixed window of data memory out over a valid/ready
// port. It reads that window through the second port of the memory.
//
// Each word takes three states:
//   READ - a one-cycle rd_en pulse goes out.
//   WAIT - rd_data is captured.
//   SEND - the word is held until the consumer accepts it.
// Only one read is ever outstanding. All outputs are registered.

module mem_dump_monitor #(
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        ADDR_W     = 10,
    parameter int unsigned        SENT_ADDR  = 499,
    parameter logic [DATA_W-1:0]  SENT_VAL   = 'h1f4,
    parameter int unsigned        DUMP_BASE  = 0,
    parameter int unsigned        DUMP_WORDS = 1000,
    parameter int unsigned        TIMEOUT    = 1048576,
    parameter int unsigned        CYC_W      = 32
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              dump_last,
    output logic              done,
    output logic              timeout,
    output logic [CYC_W-1:0]  cycle_count
);

    // Parameters resized once to the widths they are compared against.
    localparam logic [ADDR_W-1:0] L_SENT_ADDR = ADDR_W'(SENT_ADDR);
    localparam logic [ADDR_W-1:0] L_BASE      = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W-1:0] L_LAST_IDX  = ADDR_W'(DUMP_WORDS - 1);
    localparam logic [CYC_W-1:0]  L_WDOG_LAST = CYC_W'(TIMEOUT - 1);
    localparam bit                L_WDOG_EN   = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_RUN,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_dump_valid;
    logic [DATA_W-1:0] r_dump_data;
    logic [ADDR_W-1:0] r_dump_addr;
    logic              r_dump_last;
    logic              r_done;
    logic              r_timeout;
    logic [CYC_W-1:0]  r_cycle_count;

    logic w_sentinel;
    logic w_wdog_fire;
    logic w_last_idx;
    logic w_cc_sat;

    // The sentinel needs all three: the strobe, the exact address and the
    // exact value. A store to the watched word with any other value is
    // ordinary traffic.
    assign w_sentinel  = wr_en && (wr_addr == L_SENT_ADDR) && (wr_data == SENT_VAL);

    // The watchdog fires on the edge that would otherwise count cycle
    // TIMEOUT. Because of that, a watchdog dump reports TIMEOUT-1.
    assign w_wdog_fire = L_WDOG_EN && (r_cycle_count == L_WDOG_LAST);

    assign w_last_idx  = (r_idx == L_LAST_IDX);
    assign w_cc_sat    = &r_cycle_count;

    // Single FSM.
    // RUN waits for a trigger. READ/WAIT/SEND walk the dump window. DONE is
    // terminal until the next reset.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state       <= S_RUN;
            r_idx         <= '0;
            r_rd_en       <= 1'b0;
            r_rd_addr     <= '0;
            r_dump_valid  <= 1'b0;
            r_dump_data   <= '0;
            r_dump_addr   <= '0;
            r_dump_last   <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    // The sentinel takes priority over the watchdog. The
                    // counter freezes on the trigger edge, so it reports the
                    // number of RUN edges that came before the trigger.
                    if (w_sentinel) begin
                        r_state   <= S_READ;
                        r_timeout <= 1'b0;
                        r_idx     <= '0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= L_BASE;
                    end else if (w_wdog_fire) begin
                        r_state   <= S_READ;
                        r_timeout <= 1'b1;
                        r_idx     <= '0;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= L_BASE;
                    end else if (!w_cc_sat) begin
                        r_cycle_count <= r_cycle_count + CYC_W'(1);
                    end
                end

                S_READ: begin
                    // The RAM samples the request on this edge. Dropping
                    // rd_en here keeps the request a one-cycle pulse.
                    r_rd_en <= 1'b0;
                    r_state <= S_WAIT;
                end

                S_WAIT: begin
                    // rd_data now holds the word addressed in READ. rd_addr
                    // has not moved since then, so it also gives the word's
                    // address.
                    r_dump_data  <= rd_data;
                    r_dump_addr  <= r_rd_addr;
                    r_dump_last  <= w_last_idx;
                    r_dump_valid <= 1'b1;
                    r_state      <= S_SEND;
                end

                S_SEND: begin
                    // dump_valid is always high in this state, so dump_ready
                    // is never examined while no word is offered.
                    if (dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if (r_dump_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // Issue the next read right away, which keeps the
                            // cost at three cycles per word. The address
                            // wraps modulo the memory size.
                            r_idx     <= r_idx + ADDR_W'(1);
                            r_rd_addr <= r_rd_addr + ADDR_W'(1);
                            r_rd_en   <= 1'b1;
                            r_state   <= S_READ;
                        end
                    end
                end

                S_DONE: begin
                    r_done <= 1'b1;
                end

                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign rd_en       = r_rd_en;
    assign rd_addr     = r_rd_addr;
    assign dump_valid  = r_dump_valid;
    assign dump_data   = r_dump_data;
    assign dump_addr   = r_dump_addr;
    assign dump_last   = r_dump_last;
    assign done        = r_done;
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_mem_dump_monitor.sv
// Testbench for mem_dump_monitor.
// Four instances with different parameter sets share one clock, one reset,
// one memory model and one write bus. Each instance has its own write enable
// and its own read port, so only the instance under test sees the stores.
//   A (0): defaults
//   B (1): TIMEOUT=50, DUMP_WORDS=16
//   C (2): TIMEOUT=0, CYC_W=8, DUMP_WORDS=4
//   D (3): DUMP_BASE=1020, DUMP_WORDS=8

module tb_mem_dump_monitor;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        wr_en;
    logic [9:0]        wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        rdy;
    logic [3:0][31:0]  rd_data;
    logic              mem_init;
    logic [31:0]       mem [1024];

    wire  [3:0]        rd_en;
    wire  [3:0][9:0]   rd_addr;
    wire  [3:0]        dump_valid;
    wire  [3:0][31:0]  dump_data;
    wire  [3:0][9:0]   dump_addr;
    wire  [3:0]        dump_last;
    wire  [3:0]        done;
    wire  [3:0]        tmo;
    wire  [3:0][31:0]  cc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Data memory: loaded with a known pattern, updated by the snooped writes.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
        end else if (|wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // One synchronous read port per instance.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rd_en[k]) rd_data[k] <= mem[rd_addr[k]];
        end
    end

    mem_dump_monitor u_a (
        .CLK(clk), .reset(rst_n),
        .wr_en(wr_en[0]), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
        .dump_valid(dump_valid[0]), .dump_ready(rdy[0]),
        .dump_data(dump_data[0]), .dump_addr(dump_addr[0]),
        .dump_last(dump_last[0]), .done(done[0]), .timeout(tmo[0]),
        .cycle_count(cc[0])
    );

    mem_dump_monitor #(.TIMEOUT(50), .DUMP_WORDS(16)) u_b (
        .CLK(clk), .reset(rst_n),
        .wr_en(wr_en[1]), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
        .dump_valid(dump_valid[1]), .dump_ready(rdy[1]),
        .dump_data(dump_data[1]), .dump_addr(dump_addr[1]),
        .dump_last(dump_last[1]), .done(done[1]), .timeout(tmo[1]),
        .cycle_count(cc[1])
    );

    mem_dump_monitor #(.TIMEOUT(0), .CYC_W(8), .DUMP_WORDS(4)) u_c (
        .CLK(clk), .reset(rst_n),
        .wr_en(wr_en[2]), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]),
        .dump_valid(dump_valid[2]), .dump_ready(rdy[2]),
        .dump_data(dump_data[2]), .dump_addr(dump_addr[2]),
        .dump_last(dump_last[2]), .done(done[2]), .timeout(tmo[2]),
        .cycle_count(cc[2][7:0])
    );
    assign cc[2][31:8] = '0;

    mem_dump_monitor #(.DUMP_BASE(1020), .DUMP_WORDS(8)) u_d (
        .CLK(clk), .reset(rst_n),
        .wr_en(wr_en[3]), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en[3]), .rd_addr(rd_addr[3]), .rd_data(rd_data[3]),
        .dump_valid(dump_valid[3]), .dump_ready(rdy[3]),
        .dump_data(dump_data[3]), .dump_addr(dump_addr[3]),
        .dump_last(dump_last[3]), .done(done[3]), .timeout(tmo[3]),
        .cycle_count(cc[3])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int k);
        chk("idle_rd_en",      rd_en[k],      0);
        chk("idle_rd_addr",    rd_addr[k],    0);
        chk("idle_dump_valid", dump_valid[k], 0);
        chk("idle_dump_data",  dump_data[k],  0);
        chk("idle_dump_addr",  dump_addr[k],  0);
        chk("idle_dump_last",  dump_last[k],  0);
        chk("idle_done",       done[k],       0);
        chk("idle_timeout",    tmo[k],        0);
        chk("idle_cycle_cnt",  cc[k],         0);
    endtask

    // Pulse reset and return at the negedge on which it is released.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_en = '0;
        rdy   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive a store. It is sampled at the next posedge and cleared by the
    // caller's next negedge.
    task automatic drive_write(input int k, input int addr, input logic [31:0] data);
        wr_addr = 10'(addr);
        wr_data = data;
        wr_en   = '0;
        wr_en[k] = 1'b1;
    endtask

    // Called on the negedge just before the trigger edge E0. The sample at
    // t=1 sees the state after E0. The task consumes the whole dump, checking
    // every offered word against the memory model and the expected address
    // sequence. t_last is the sample on which the final word was accepted.
    task automatic run_dump(input int k, input int base, input int n, input int pct,
                            output int t_last);
        int   widx;
        int   t;
        int   addr;
        logic prev_rd;
        widx    = 0;
        t       = 0;
        prev_rd = 1'b0;
        t_last  = -1;
        while (widx < n && t < 20000) begin
            @(negedge clk);
            wr_en = '0;
            t++;
            addr = (base + widx) % 1024;
            if (t == 1) chk("first_rd_en", rd_en[k], 1);
            if (t == 3) chk("first_valid", dump_valid[k], 1);
            if (rd_en[k]) begin
                chk("rd_addr",     rd_addr[k],    addr);
                chk("rd_pulse",    prev_rd,       0);
                chk("rd_vs_valid", dump_valid[k], 0);
            end
            prev_rd = rd_en[k];
            if (dump_valid[k]) begin
                chk("dump_addr",  dump_addr[k], addr);
                chk("dump_data",  dump_data[k], mem[addr]);
                chk("dump_last",  dump_last[k], (widx == n - 1));
                chk("done_early", done[k],      0);
            end
            rdy[k] = ($urandom_range(99) < pct);
            if (dump_valid[k] && rdy[k]) begin
                widx++;
                t_last = t;
            end
        end
        chk("dump_count", widx, n);
        @(negedge clk);
        rdy[k] = 1'b0;
        chk("done_set",       done[k],       1);
        chk("valid_after",    dump_valid[k], 0);
        chk("rd_en_after",    rd_en[k],      0);
        $display("[TB] dump inst %0d base %0d: %0d words, last accept at sample %0d",
                 k, base, widx, t_last);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        int  t;
        bit  seen;
        rst_n    = 1'b0;
        mem_init = 1'b1;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        rdy      = '0;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        for (int k = 0; k < 4; k++) check_idle(k);
        rst_n = 1'b1;

        // 1: sentinel after 200 RUN cycles, full dump, ready tied high.
        repeat (200) @(negedge clk);
        drive_write(0, 499, 32'h1f4);
        run_dump(0, 0, 1000, 100, t);
        chk("t1_cycles",    t,     3000);
        chk("t1_timeout",   tmo[0], 0);
        chk("t1_cycle_cnt", cc[0], 200);
        // A sentinel in DONE must be ignored.
        drive_write(0, 499, 32'h1f4);
        @(negedge clk);
        wr_en = '0;
        @(negedge clk);
        chk("done_ignore_rd", rd_en[0], 0);
        chk("done_hold",      done[0],  1);
        // C has no watchdog: its counter saturates at 255 and never triggers.
        chk("nowdog_cc",    cc[2],         255);
        chk("nowdog_rd",    rd_en[2],      0);
        chk("nowdog_valid", dump_valid[2], 0);
        chk("nowdog_done",  done[2],       0);
        $display("[TB] sentinel dump and disabled watchdog checked");

        // 2: near-miss stores, then the real sentinel with 30% ready duty.
        apply_reset();
        seen = 1'b0;
        @(negedge clk);
        drive_write(0, 499, 32'h1f3);
        @(negedge clk);
        drive_write(0, 498, 32'h1f4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en = '0;
            if (rd_en[0] || dump_valid[0]) seen = 1'b1;
        end
        chk("near_miss_no_trig", seen, 0);
        drive_write(0, 499, 32'h1f4);
        run_dump(0, 0, 1000, 30, t);
        chk("t2_cycle_cnt", cc[0], 6);
        chk("t2_timeout",   tmo[0], 0);

        // 3: watchdog on B fires on the 50th RUN edge.
        apply_reset();
        repeat (49) @(negedge clk);
        chk("wdog_not_yet", rd_en[1], 0);
        chk("wdog_cc_49",   cc[1],    49);
        run_dump(1, 0, 16, 100, t);
        chk("wdog_cycles",  t,      48);
        chk("wdog_timeout", tmo[1], 1);
        chk("wdog_cc",      cc[1],  49);

        // 3b: sentinel on the same edge as the watchdog: the sentinel wins.
        apply_reset();
        repeat (49) @(negedge clk);
        drive_write(1, 499, 32'h1f4);
        run_dump(1, 0, 16, 100, t);
        chk("tie_timeout", tmo[1], 0);
        chk("tie_cc",      cc[1],  49);

        // 4: window wrapping past the top of memory, sentinel on the 1st edge.
        apply_reset();
        drive_write(3, 499, 32'h1f4);
        run_dump(3, 1020, 8, 100, t);
        chk("wrap_cycles", t,     24);
        chk("wrap_cc",     cc[3], 0);

        // 5: reset while word 17 is waiting in SEND.
        apply_reset();
        drive_write(0, 499, 32'h1f4);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            wr_en = '0;
            if (dump_valid[0] && dump_addr[0] == 10'd17) seen = 1'b1;
            rdy[0] = !seen;
        end
        chk("reach_word17", seen, 1);
        @(negedge clk);
        chk("stall_valid", dump_valid[0], 1);
        chk("stall_addr",  dump_addr[0],  17);
        rst_n = 1'b0;
        #1;
        check_idle(0);
        @(negedge clk);
        rst_n  = 1'b1;
        rdy[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("restart_cc", cc[0], 4);
        drive_write(0, 499, 32'h1f4);
        run_dump(0, 0, 1000, 100, t);
        chk("restart_cycles", t,     3000);
        chk("restart_cc_frz", cc[0], 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
